// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC generation and instruction fetch for the RV32UI core.
//               Owns the PC, drives the combinational imem address and
//               registers {pc, instr} into a one-entry valid/ready slot
//               toward decode. Handles branch/jump redirects and turns a
//               misaligned redirect target into a fault marker slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] BASE_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misaligned,
    output logic [31:0] fetch_count
);

    // BOOT : one idle cycle after reset so imem settles before the first fetch
    // RUN  : normal fetching whenever the output slot can take a new entry
    // FAULT: a misaligned-target marker was issued; wait for a redirect
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [31:0] C_PC_STEP = 32'd4;

    logic [1:0]  state_q,          state_d;
    logic [31:0] pc_q,             pc_d;
    logic        out_valid_q,      out_valid_d;
    logic [31:0] out_pc_q,         out_pc_d;
    logic [31:0] out_instr_q,      out_instr_d;
    logic        out_misaligned_q, out_misaligned_d;
    logic [31:0] fetch_count_q,    fetch_count_d;

    logic        w_fire;
    logic        w_slot_free;
    logic        w_redirect_aligned;

    // Handshake qualifiers for the output slot and redirect target alignment
    always_comb begin
        w_fire             = out_valid_q & out_ready;
        w_slot_free        = ~out_valid_q | out_ready;
        w_redirect_aligned = (redirect_pc[1:0] == 2'b00);
    end

    // Next-state logic: redirect beats fetch/stall; BOOT ignores redirects
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        out_valid_d      = out_valid_q;
        out_pc_d         = out_pc_q;
        out_instr_d      = out_instr_q;
        out_misaligned_d = out_misaligned_q;
        fetch_count_d    = fetch_count_q;

        // Every accepted slot counts, even one flushed by a same-cycle redirect
        if (w_fire) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN, ST_FAULT: begin
                if (redirect_valid) begin
                    if (w_redirect_aligned) begin
                        // Flush the slot; the target is fetched next cycle
                        out_valid_d = 1'b0;
                        pc_d        = redirect_pc;
                        state_d     = ST_RUN;
                    end else begin
                        // Emit a NOP fault marker carrying the bad target;
                        // the PC is left alone since the target is unusable
                        out_valid_d      = 1'b1;
                        out_pc_d         = redirect_pc;
                        out_instr_d      = NOP_INSTR;
                        out_misaligned_d = 1'b1;
                        state_d          = ST_FAULT;
                    end
                end else if (state_q == ST_RUN) begin
                    if (w_slot_free) begin
                        out_valid_d      = 1'b1;
                        out_pc_d         = pc_q;
                        out_instr_d      = imem_instr;
                        out_misaligned_d = 1'b0;
                        pc_d             = pc_q + C_PC_STEP;
                    end
                end else begin
                    // FAULT: marker drains once decode takes it, no refetch
                    if (w_fire) begin
                        out_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_BOOT;
            pc_q             <= BASE_PC;
            out_valid_q      <= 1'b0;
            out_pc_q         <= 32'h0000_0000;
            out_instr_q      <= 32'h0000_0000;
            out_misaligned_q <= 1'b0;
            fetch_count_q    <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_instr_q      <= out_instr_d;
            out_misaligned_q <= out_misaligned_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    // Output drive; imem address is the live PC so imem answers same cycle
    always_comb begin
        imem_pc        = pc_q;
        out_valid      = out_valid_q;
        out_pc         = out_pc_q;
        out_instr      = out_instr_q;
        out_misaligned = out_misaligned_q;
        fetch_count    = fetch_count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed testbench for fetch_stage. imem model returns
//               0x1000_0000 + word index of the requested address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misaligned;
    logic [31:0] fetch_count;

    int n_checks;
    int n_fail;

    fetch_stage #(
        .BASE_PC   (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misaligned (out_misaligned),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: word k holds 0x1000_0000 + k
    assign imem_instr = 32'h1000_0000 + {2'b00, imem_pc[31:2]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_imem_pc", imem_pc, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_misal", {31'b0, out_misaligned}, 32'd0);

        // 1: BOOT cycle, then one instruction per cycle
        rst = 1'b0;
        tick();
        check("boot_valid", {31'b0, out_valid}, 32'd0);
        check("boot_imem_pc", imem_pc, 32'h0);
        tick();
        check("f0_valid", {31'b0, out_valid}, 32'd1);
        check("f0_pc", out_pc, 32'h0);
        check("f0_instr", out_instr, 32'h1000_0000);
        check("f0_count", fetch_count, 32'd0);
        tick();
        check("f1_pc", out_pc, 32'h4);
        check("f1_instr", out_instr, 32'h1000_0001);
        check("f1_count", fetch_count, 32'd1);
        tick();
        check("f2_pc", out_pc, 32'h8);
        check("f2_instr", out_instr, 32'h1000_0002);
        check("f2_count", fetch_count, 32'd2);

        // 2: stall for three cycles, then release without skip/duplicate
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_pc", out_pc, 32'h8);
            check("stall_instr", out_instr, 32'h1000_0002);
            check("stall_imem_pc", imem_pc, 32'hC);
            check("stall_count", fetch_count, 32'd2);
        end
        out_ready = 1'b1;
        tick();
        check("rel_pc", out_pc, 32'hC);
        check("rel_instr", out_instr, 32'h1000_0003);
        check("rel_count", fetch_count, 32'd3);

        // 3: aligned redirect while slot valid (same-cycle fire still counts)
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        check("rd_valid", {31'b0, out_valid}, 32'd0);
        check("rd_imem_pc", imem_pc, 32'h40);
        check("rd_count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        tick();
        check("rd_f_valid", {31'b0, out_valid}, 32'd1);
        check("rd_f_pc", out_pc, 32'h40);
        check("rd_f_instr", out_instr, 32'h1000_0010);
        check("rd_f_count", fetch_count, 32'd4);

        // 4: misaligned redirect produces a held fault marker
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        check("mis_valid", {31'b0, out_valid}, 32'd1);
        check("mis_flag", {31'b0, out_misaligned}, 32'd1);
        check("mis_pc", out_pc, 32'h42);
        check("mis_instr", out_instr, 32'h0000_0013);
        check("mis_imem_pc", imem_pc, 32'h44);
        check("mis_count", fetch_count, 32'd4);
        tick();
        check("mis_hold_valid", {31'b0, out_valid}, 32'd1);
        check("mis_hold_pc", out_pc, 32'h42);
        out_ready = 1'b1;
        tick();
        check("mis_fire_valid", {31'b0, out_valid}, 32'd0);
        check("mis_fire_count", fetch_count, 32'd5);
        tick();
        check("fault_idle_valid", {31'b0, out_valid}, 32'd0);
        check("fault_idle_count", fetch_count, 32'd5);
        check("fault_idle_imem", imem_pc, 32'h44);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check("resume_valid", {31'b0, out_valid}, 32'd0);
        check("resume_imem", imem_pc, 32'h80);
        tick();
        check("resume_f_valid", {31'b0, out_valid}, 32'd1);
        check("resume_f_pc", out_pc, 32'h80);
        check("resume_f_instr", out_instr, 32'h1000_0020);
        check("resume_f_misal", {31'b0, out_misaligned}, 32'd0);

        // 5: PC wrap at top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        check("wrap_rd_imem", imem_pc, 32'hFFFF_FFF8);
        check("wrap_rd_count", fetch_count, 32'd6);
        tick();
        check("wrap0_pc", out_pc, 32'hFFFF_FFF8);
        check("wrap0_instr", out_instr, 32'h4FFF_FFFE);
        tick();
        check("wrap1_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap1_instr", out_instr, 32'h4FFF_FFFF);
        check("wrap1_count", fetch_count, 32'd7);
        tick();
        check("wrap2_pc", out_pc, 32'h0);
        check("wrap2_instr", out_instr, 32'h1000_0000);
        check("wrap2_imem", imem_pc, 32'h4);
        check("wrap2_count", fetch_count, 32'd8);

        // 6: reset mid-stall, then a redirect during BOOT is ignored
        out_ready = 1'b0;
        tick();
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_count", fetch_count, 32'd0);
        check("mid_rst_imem", imem_pc, 32'h0);
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("boot_rd_imem", imem_pc, 32'h0);
        check("boot_rd_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("post_boot_valid", {31'b0, out_valid}, 32'd1);
        check("post_boot_pc", out_pc, 32'h0);
        check("post_boot_instr", out_instr, 32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
